// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encodings
// and the operand-width legality check.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    localparam int SERIAL_MIN_N = 2;

    function automatic bit serial_width_ok(input int n);
        return n >= SERIAL_MIN_N;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// Combinational full adder built from two half adders and an OR, matching the
// structure of the subtractor cells it sits beside.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_s;
    logic g0_s;
    logic g1_s;

    half_adder u_ha0 (.x(x),   .y(y),  .s(p_s), .c(g0_s));
    half_adder u_ha1 (.x(p_s), .y(ci), .s(s),   .c(g1_s));

    // Carry out is raised by either half-adder stage.
    always_comb begin
        co = g0_s | g1_s;
    end

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR form the full-adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    // Sum and carry of two bits.
    always_comb begin
        s = x ^ y;
        c = x & y;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell and a registered carry walk the
// operands LSB-first, one bit per cycle, behind a start/busy/done handshake.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_PRE  = CW'(N - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    if (!serial_width_ok(N)) begin : g_bad_width
        $error("serial_adder: N must be at least 2");
    end

    arith_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-2:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic          c_msb_q, c_msb_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          fa_s;
    logic          fa_c;
    logic          load_s;
    logic [N-1:0]  acc_next_s;

    fa_bit u_fa (
        .x (a_sr_q[0]),
        .y (b_sr_q[0]),
        .ci(carry_q),
        .s (fa_s),
        .co(fa_c)
    );

    // Next-state, datapath shift and output-update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        c_msb_d    = c_msb_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        load_s     = 1'b0;
        acc_next_s = {fa_s, acc_q};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // New sum bit enters at the top; the completed word is acc_next_s.
                a_sr_d  = {1'b0, a_sr_q[N-1:1]};
                b_sr_d  = {1'b0, b_sr_q[N-1:1]};
                acc_d   = acc_next_s[N-1:1];
                carry_d = fa_c;
                if (cnt_q == CNT_PRE) begin
                    c_msb_d = fa_c;
                end else begin
                    c_msb_d = c_msb_q;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_d   = acc_next_s;
                    cout_d  = fa_c;
                    ovf_d   = c_msb_q ^ fa_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (start) begin
                    load_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            state_d = ST_RUN;
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            c_msb_d = 1'b0;
            cnt_d   = '0;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at N=8, plus a second N=2 instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout, ovf;
    logic [7:0] sum;

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    // Launch one N=8 op from a negedge; report cycles to done and busy cycles seen.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                           output int cycles, output int busy_cnt, output bit seen);
        a = av; b = bv; cin = ci; start = 1'b1;
        cycles = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && cycles < 30) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        n_checks++;
        if ({busy2, done2, sum2, cout2, ovf2} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset2: got busy=%b done=%b sum=%b cout=%b ovf=%b, want all 0",
                     busy2, done2, sum2, cout2, ovf2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int cyc, bc; bit seen;
        run_op8(8'h5A, 8'h3C, 1'b0, cyc, bc, seen);
        n_checks++;
        if (!seen || cyc !== 9) begin
            n_fail++; $display("FAIL basic_latency: got %0d cycles (seen=%b), want 9", cyc, seen);
        end
        n_checks++;
        if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL basic_result: got sum=%h cout=%b ovf=%b, want 96/0/1", sum, cout, ovf);
        end
        n_checks++;
        if (bc !== 8) begin
            n_fail++; $display("FAIL basic_busy: got %0d busy cycles, want 8", bc);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_wrap;
        int cyc, bc; bit seen;
        run_op8(8'hFF, 8'h01, 1'b0, cyc, bc, seen);
        n_checks++;
        if (!seen || {sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL wrap_unsigned: got sum=%h cout=%b ovf=%b, want 00/1/0", sum, cout, ovf);
        end
        @(negedge clk);
        run_op8(8'h7F, 8'h00, 1'b1, cyc, bc, seen);
        n_checks++;
        if (!seen || {sum, cout, ovf} !== {8'h80, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wrap_signed: got sum=%h cout=%b ovf=%b, want 80/0/1", sum, cout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy;
        int cyc, dones;
        bit seen;
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) begin
                a = 8'hF0; b = 8'h0F; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (!seen || sum !== 8'h03 || cyc !== 9) begin
            n_fail++; $display("FAIL ignore_busy_result: got sum=%h at cycle %0d, want 03 at 9", sum, cyc);
        end
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_busy_idle: got %0d extra dones busy=%b, want 0/0", dones, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] opa [3] = '{8'h10, 8'h80, 8'h33};
        logic [7:0] opb [3] = '{8'h20, 8'h80, 8'h44};
        logic       opc [3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] exp [3] = '{{8'h30, 2'b00}, {8'h00, 2'b11}, {8'h78, 2'b00}};
        int cyc, last, k;
        a = opa[0]; b = opb[0]; cin = opc[0]; start = 1'b1;
        cyc = 0; last = 0; k = 0;
        while (k < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                n_checks++;
                if ({sum, cout, ovf} !== exp[k]) begin
                    n_fail++; $display("FAIL b2b_result%0d: got %h/%b/%b, want %h/%b/%b",
                                       k, sum, cout, ovf, exp[k][9:2], exp[k][1], exp[k][0]);
                end
                n_checks++;
                if (cyc - last !== 9) begin
                    n_fail++; $display("FAIL b2b_interval%0d: got %0d cycles, want 9", k, cyc - last);
                end
                last = cyc;
                k++;
                if (k < 3) begin
                    a = opa[k]; b = opb[k]; cin = opc[k];
                end else begin
                    start = 1'b0;
                end
            end else if (k > 0 && cyc - last == 4) begin
                n_checks++;
                if ({sum, cout, ovf} !== exp[k-1]) begin
                    n_fail++; $display("FAIL b2b_hold%0d: got %h/%b/%b during RUN, want prior result",
                                       k, sum, cout, ovf);
                end
            end
        end
        n_checks++;
        if (k !== 3) begin
            n_fail++; $display("FAIL b2b_timeout: got %0d completions, want 3", k);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midop;
        int cyc, bc, dones; bit seen;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, sum, cout, ovf} !== 12'h000) begin
            n_fail++; $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                               busy, done, sum, cout, ovf);
        end
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++; $display("FAIL midop_no_done: got %0d dones, want 0", dones);
        end
        run_op8(8'h12, 8'h34, 1'b0, cyc, bc, seen);
        n_checks++;
        if (!seen || {sum, cout, ovf} !== {8'h46, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL midop_recover: got sum=%h cout=%b ovf=%b, want 46/0/0", sum, cout, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_n2;
        int cyc; bit seen;
        a2 = 2'b11; b2 = 2'b01; cin2 = 1'b1; start2 = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            start2 = 1'b0;
            if (done2) seen = 1'b1;
        end
        n_checks++;
        if (!seen || cyc !== 3) begin
            n_fail++; $display("FAIL n2_latency: got %0d cycles (seen=%b), want 3", cyc, seen);
        end
        n_checks++;
        if ({sum2, cout2, ovf2} !== {2'b01, 1'b1, 1'b0} || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL n2_result: got sum=%b cout=%b ovf=%b busy=%b, want 01/1/0/0",
                               sum2, cout2, ovf2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midop();
        test_n2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
